// File: rtl/bp_mc_bridge_pkg.sv
// Shared types for the BlackParrot<->manycore bridge: rx FSM states, a trimmed
// bp_cce_mem_msg_s layout, manycore load info and the mask/size decode result.
package bp_mc_bridge_pkg;

  localparam int unsigned paddr_width_gp    = 40;
  localparam int unsigned cce_data_width_gp = 64;
  localparam logic [31:0] deadbeef_gp       = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    e_rx_idle,
    e_rx_cmd,
    e_rx_resp,
    e_rx_ret
  } bp_mc_rx_state_e;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1 = 3'd0,
    e_mem_msg_size_2 = 3'd1,
    e_mem_msg_size_4 = 3'd2,
    e_mem_msg_size_8 = 3'd3
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [3:0] lce_id;
    logic [2:0] way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_payload_s         payload;
    bp_mem_msg_size_e            size;
    logic [paddr_width_gp-1:0]   addr;
    bp_cce_mem_cmd_type_e        msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    logic [cce_data_width_gp-1:0] data;
    bp_cce_mem_msg_header_s       header;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  typedef struct packed {
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } bsg_manycore_load_info_s;

  typedef struct packed {
    bp_mem_msg_size_e size;
    logic [1:0]       offset;
    logic             legal;
  } bp_mc_mask_decode_s;

  function automatic logic [31:0] size_mask(bp_mem_msg_size_e size);
    case (size)
      e_mem_msg_size_1: return 32'h0000_00FF;
      e_mem_msg_size_2: return 32'h0000_FFFF;
      default:          return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/bp_mc_mask_decode.sv
// Combinational decode of a manycore store mask or load info into an access
// size, byte offset within the word and a legality flag.
module bp_mc_mask_decode
  import bp_mc_bridge_pkg::*;
(
  input  logic                    we_i,
  input  logic [3:0]              mask_i,
  input  bsg_manycore_load_info_s load_info_i,
  output bp_mc_mask_decode_s      decode_o
);

  always_comb begin
    decode_o.size   = e_mem_msg_size_4;
    decode_o.offset = 2'd0;
    decode_o.legal  = 1'b1;
    if (we_i) begin
      case (mask_i)
        4'b0001: begin decode_o.size = e_mem_msg_size_1; decode_o.offset = 2'd0; end
        4'b0010: begin decode_o.size = e_mem_msg_size_1; decode_o.offset = 2'd1; end
        4'b0100: begin decode_o.size = e_mem_msg_size_1; decode_o.offset = 2'd2; end
        4'b1000: begin decode_o.size = e_mem_msg_size_1; decode_o.offset = 2'd3; end
        4'b0011: begin decode_o.size = e_mem_msg_size_2; decode_o.offset = 2'd0; end
        4'b1100: begin decode_o.size = e_mem_msg_size_2; decode_o.offset = 2'd2; end
        4'b1111: begin decode_o.size = e_mem_msg_size_4; decode_o.offset = 2'd0; end
        default: decode_o.legal = 1'b0;
      endcase
    end else begin
      if (load_info_i.is_byte_op) begin
        decode_o.size = e_mem_msg_size_1;
      end else if (load_info_i.is_hex_op) begin
        decode_o.size = e_mem_msg_size_2;
      end
      decode_o.offset = load_info_i.part_sel;
    end
  end

endmodule

// File: rtl/bp_mc_rx_to_cce.sv
// Manycore -> BP receive path: one uncached io_cmd per endpoint request, in order.
// Define BP_MC_RX_TIMEOUT_EN to add a response watchdog (returns 0xDEADBEEF, sets err_o).
module bp_mc_rx_to_cce
  import bp_mc_bridge_pkg::*;
#(
  parameter int unsigned               mc_data_width_p  = 32,
  parameter int unsigned               mc_addr_width_p  = 28,
  parameter logic [paddr_width_gp-1:0] io_base_paddr_p  = '0,
  parameter int unsigned               timeout_cycles_p = 1024
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            in_v_i,
  input  logic [mc_data_width_p-1:0]      in_data_i,
  input  logic [(mc_data_width_p/8)-1:0]  in_mask_i,
  input  logic [mc_addr_width_p-1:0]      in_addr_i,
  input  logic                            in_we_i,
  input  bsg_manycore_load_info_s         in_load_info_i,
  output logic                            in_yumi_o,
  output logic [mc_data_width_p-1:0]      returning_data_o,
  output logic                            returning_v_o,
  output logic [cce_mem_msg_width_gp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_yumi_i,
  input  logic [cce_mem_msg_width_gp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_ready_o,
  output logic                            err_o
);

  bp_mc_rx_state_e      state_q, state_d;
  bp_cce_mem_msg_s      cmd_q, cmd_d;
  logic [1:0]           offset_q, offset_d;
  logic [31:0]          data_q, data_d;
  logic                 bypass_q, bypass_d;
  logic                 err_q, err_d;
  logic                 stale_q;
  logic                 timeout_hit;
  bp_mc_mask_decode_s   dec;
  bp_cce_mem_msg_s      resp_s;
  logic [31:0]          store_data;
  logic [31:0]          load_data;
  logic                 unused_resp;

  bp_mc_mask_decode u_mask_decode (
    .we_i        (in_we_i),
    .mask_i      (in_mask_i),
    .load_info_i (in_load_info_i),
    .decode_o    (dec)
  );

  assign resp_s      = io_resp_i;
  assign unused_resp = ^{resp_s.header, resp_s.data[cce_data_width_gp-1:32]};

  // Store lanes are moved down to bit 0; load data is moved back up to its lane.
  assign store_data = (in_data_i >> {dec.offset, 3'b000}) & size_mask(dec.size);
  assign load_data  = (resp_s.data[31:0] & size_mask(cmd_q.header.size))
                      << {offset_q, 3'b000};

`ifdef BP_MC_RX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout_cycles_p + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stale_d;

  assign timeout_hit = (state_q == e_rx_resp) && !bypass_q && !io_resp_v_i
                       && (cnt_q == CntW'(timeout_cycles_p - 1));

  // A response that shows up after the watchdog fired is swallowed in IDLE.
  always_comb begin
    cnt_d   = cnt_q;
    stale_d = stale_q;
    if (state_q == e_rx_cmd) begin
      cnt_d = '0;
    end else if (state_q == e_rx_resp) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout_hit) begin
      stale_d = 1'b1;
    end else if ((state_q == e_rx_idle) && io_resp_v_i) begin
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`else
  localparam int unsigned unused_timeout_lp = timeout_cycles_p;

  assign timeout_hit = 1'b0;
  assign stale_q     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    offset_d = offset_q;
    data_d   = data_q;
    bypass_d = bypass_q;
    err_d    = err_q;
    unique case (state_q)
      e_rx_idle: begin
        if (in_v_i) begin
          cmd_d.header.msg_type = in_we_i ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
          cmd_d.header.addr     = io_base_paddr_p
                                  | (paddr_width_gp'(in_addr_i) << 2)
                                  | paddr_width_gp'(dec.offset);
          cmd_d.header.size     = dec.size;
          cmd_d.header.payload  = '0;
          cmd_d.data            = in_we_i ? cce_data_width_gp'(store_data) : '0;
          offset_d              = dec.offset;
          data_d                = '0;
          if (dec.legal) begin
            bypass_d = 1'b0;
            state_d  = e_rx_cmd;
          end else begin
            bypass_d = 1'b1;
            err_d    = 1'b1;
            state_d  = e_rx_resp;
          end
        end
      end
      e_rx_cmd: begin
        if (io_cmd_yumi_i) begin
          state_d = e_rx_resp;
        end
      end
      e_rx_resp: begin
        if (bypass_q) begin
          state_d = e_rx_ret;
        end else if (io_resp_v_i) begin
          data_d  = (cmd_q.header.msg_type == e_cce_mem_uc_wr) ? '0 : load_data;
          state_d = e_rx_ret;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          data_d  = deadbeef_gp;
          state_d = e_rx_ret;
        end
      end
      e_rx_ret: begin
        state_d = e_rx_idle;
      end
      default: begin
        state_d = e_rx_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_rx_idle;
      cmd_q    <= '0;
      offset_q <= '0;
      data_q   <= '0;
      bypass_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      offset_q <= offset_d;
      data_q   <= data_d;
      bypass_q <= bypass_d;
      err_q    <= err_d;
    end
  end

  assign io_cmd_o         = cmd_q;
  assign io_cmd_v_o       = (state_q == e_rx_cmd);
  assign io_resp_ready_o  = ((state_q == e_rx_resp) && !bypass_q)
                            || ((state_q == e_rx_idle) && stale_q);
  assign in_yumi_o        = (state_q == e_rx_resp) && (bypass_q || io_resp_v_i || timeout_hit);
  assign returning_v_o    = (state_q == e_rx_ret);
  assign returning_data_o = data_q;
  assign err_o            = err_q;

endmodule
